// File: rtl/ctrl_lectura_rtc_pkg.sv
// Shared types and constants for the RTC read-sequence controller.
// Holds the state encoding, sequence limits and the bus-strobe decode per state.
package ctrl_lectura_rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIR    = 3'd1,
    S_ESPERA = 3'd2,
    S_LEER   = 3'd3,
    S_SIG    = 3'd4,
    S_FIN    = 3'd5
  } estado_e;

  localparam int CUENTA_MAX = 17;
  localparam int N_LECTURAS = 9;
  localparam int T_FASE_DEF = 4;
  localparam int CUENTA_W   = 5;
  localparam int IDX_W      = 4;

  typedef struct packed {
    logic en;
    logic c_s;
    logic a_d;
    logic cs_n;
    logic wr_n;
    logic rd_n;
  } bus_t;

  // Decoder and strobe levels for the state about to be entered.
  function automatic bus_t salidas(estado_e s);
    bus_t b;
    b = '{en: 1'b1, c_s: 1'b0, a_d: 1'b0, cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1};
    case (s)
      S_DIR:    b = '{en: 1'b0, c_s: 1'b0, a_d: 1'b0, cs_n: 1'b0, wr_n: 1'b0, rd_n: 1'b1};
      S_ESPERA: b = '{en: 1'b0, c_s: 1'b1, a_d: 1'b0, cs_n: 1'b0, wr_n: 1'b1, rd_n: 1'b1};
      S_LEER:   b = '{en: 1'b0, c_s: 1'b0, a_d: 1'b1, cs_n: 1'b0, wr_n: 1'b1, rd_n: 1'b0};
      S_SIG:    b = '{en: 1'b0, c_s: 1'b0, a_d: 1'b0, cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1};
      default:  b = '{en: 1'b1, c_s: 1'b0, a_d: 1'b0, cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ctrl_lectura_rtc_if.sv
// Control/data bundle between the RTC read controller and its environment.
// The controller uses the slave view; the environment drives through master.
interface ctrl_lectura_rtc_if;
  import ctrl_lectura_rtc_pkg::*;

  logic                iniciar;
  logic [7:0]          dato_in;
  logic                en;
  logic                c_s;
  logic                A_D;
  logic [CUENTA_W-1:0] cuenta;
  logic                cs_n;
  logic                wr_n;
  logic                rd_n;
  logic [7:0]          dato;
  logic [IDX_W-1:0]    dato_idx;
  logic                valido;
  logic                ocupado;
  logic                listo;

  modport master (
    output iniciar, dato_in,
    input  en, c_s, A_D, cuenta, cs_n, wr_n, rd_n, dato, dato_idx, valido, ocupado, listo
  );

  modport slave (
    input  iniciar, dato_in,
    output en, c_s, A_D, cuenta, cs_n, wr_n, rd_n, dato, dato_idx, valido, ocupado, listo
  );
endinterface

// File: rtl/ctrl_lectura_rtc_temporizador_fase.sv
// Phase down-counter: reloads to T_FASE-1 on load, decrements while count is set.
// fin is high on the last cycle of a phase (counter at zero).
module temporizador_fase #(
  parameter int T_FASE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic fin
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = 8'(T_FASE - 1);
    else if (count && cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign fin = (cnt_q == 8'd0);
endmodule

// File: rtl/ctrl_lectura_rtc.sv
// RTC read-sequence controller: walks cuenta 0..17 issuing address/data phases,
// capturing one byte on every odd step, then pulses listo.
module ctrl_lectura_rtc
  import ctrl_lectura_rtc_pkg::*;
#(
  parameter int T_FASE = T_FASE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  ctrl_lectura_rtc_if.slave   bus
);
  estado_e             estado_q, estado_d;
  logic [CUENTA_W-1:0] cuenta_q, cuenta_d;
  logic [7:0]          dato_q, dato_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valido_q, valido_d;
  logic                listo_q, listo_d;
  logic                ocupado_q, ocupado_d;
  bus_t                out_q, out_d;
  logic                fase_load, fase_count, fase_fin;

  // Timer restarts whenever the state changes, so every state entry gets a full phase.
  assign fase_load  = (estado_d != estado_q);
  assign fase_count = (estado_q == S_DIR) || (estado_q == S_ESPERA) || (estado_q == S_LEER);

  temporizador_fase #(.T_FASE(T_FASE)) u_fase (
    .clk   (clk),
    .reset (reset),
    .load  (fase_load),
    .count (fase_count),
    .fin   (fase_fin)
  );

  always_comb begin
    estado_d = estado_q;
    cuenta_d = cuenta_q;
    dato_d   = dato_q;
    idx_d    = idx_q;
    valido_d = 1'b0;
    case (estado_q)
      S_IDLE: if (bus.iniciar) begin
        cuenta_d = '0;
        estado_d = S_DIR;
      end
      S_DIR:    if (fase_fin) estado_d = S_ESPERA;
      S_ESPERA: if (fase_fin) estado_d = cuenta_q[0] ? S_LEER : S_SIG;
      S_LEER: if (fase_fin) begin
        dato_d   = bus.dato_in;
        idx_d    = cuenta_q[4:1];
        valido_d = 1'b1;
        estado_d = S_SIG;
      end
      S_SIG: begin
        if (cuenta_q == CUENTA_W'(CUENTA_MAX)) begin
          estado_d = S_FIN;
        end else begin
          cuenta_d = cuenta_q + 1'b1;
          estado_d = S_DIR;
        end
      end
      S_FIN:   estado_d = S_IDLE;
      default: estado_d = S_IDLE;
    endcase
    out_d     = salidas(estado_d);
    ocupado_d = (estado_d != S_IDLE);
    listo_d   = (estado_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= S_IDLE;
      cuenta_q  <= '0;
      dato_q    <= '0;
      idx_q     <= '0;
      valido_q  <= 1'b0;
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
      out_q     <= salidas(S_IDLE);
    end else begin
      estado_q  <= estado_d;
      cuenta_q  <= cuenta_d;
      dato_q    <= dato_d;
      idx_q     <= idx_d;
      valido_q  <= valido_d;
      listo_q   <= listo_d;
      ocupado_q <= ocupado_d;
      out_q     <= out_d;
    end
  end

  assign bus.en       = out_q.en;
  assign bus.c_s      = out_q.c_s;
  assign bus.A_D      = out_q.a_d;
  assign bus.cs_n     = out_q.cs_n;
  assign bus.wr_n     = out_q.wr_n;
  assign bus.rd_n     = out_q.rd_n;
  assign bus.cuenta   = cuenta_q;
  assign bus.dato     = dato_q;
  assign bus.dato_idx = idx_q;
  assign bus.valido   = valido_q;
  assign bus.listo    = listo_q;
  assign bus.ocupado  = ocupado_q;
endmodule
